cnt_up_down: RTL and testbench



---
 rtl/cnt_up_down_pkg.sv | 12 +
 rtl/cnt_up_down.sv | 54 +++++
 tb/tb_cnt_up_down.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cnt_up_down_pkg.sv
// Shared constants and types for the up/down counter.
// Holds the default width and the direction encoding of the 'up' input.
package cnt_up_down_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/cnt_up_down.sv
// Modulo-2^WIDTH up/down counter with registered boundary flags and a
// one-cycle wrap pulse; advances on every non-reset rising edge of sys_clk.
module cnt_up_down
  import cnt_up_down_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             up,
  output logic [WIDTH-1:0] cnt,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH:0]   ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0]   step_result;
  logic [WIDTH-1:0] cnt_next;
  logic             carry_next;
  logic             at_max_next;
  logic             at_min_next;

  // One extra bit catches the carry (up) or borrow (down); that bit is the wrap event.
  always_comb begin
    step_result = '0;
    if (dir_e'(up) == DIR_UP) begin
      step_result = {1'b0, cnt} + ONE_EXT;
    end else begin
      step_result = {1'b0, cnt} - ONE_EXT;
    end
    cnt_next    = step_result[WIDTH-1:0];
    carry_next  = step_result[WIDTH];
    at_max_next = (cnt_next == MAX_VAL);
    at_min_next = (cnt_next == '0);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt    <= '0;
      at_max <= 1'b0;
      at_min <= 1'b1;
      wrap   <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      at_max <= at_max_next;
      at_min <= at_min_next;
      wrap   <= carry_next;
    end
  end

endmodule

// File: tb/tb_cnt_up_down.sv
// Scoreboard bench for cnt_up_down: directed sequences followed by random
// direction/reset traffic, checked against an integer reference model.
module tb_cnt_up_down;

  localparam int WIDTH = 4;
  localparam int MOD   = 1 << WIDTH;

  typedef struct {
    int cnt;
    bit at_max;
    bit at_min;
    bit wrap;
  } exp_t;

  logic             sys_clk;
  logic             sys_rst;
  logic             up;
  logic [WIDTH-1:0] cnt;
  logic             at_max;
  logic             at_min;
  logic             wrap;

  exp_t sb[$];
  int   vectors;
  int   miscompares;
  int   model_cnt;

  cnt_up_down #(.WIDTH(WIDTH)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .up      (up),
    .cnt     (cnt),
    .at_max  (at_max),
    .at_min  (at_min),
    .wrap    (wrap)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Drive inputs on the falling edge and record what the next rising edge must produce.
  task automatic applyStimulus(input logic rst, input logic dir);
    exp_t e;
    int   raw;
    @(negedge sys_clk);
    sys_rst = rst;
    up      = dir;
    if (rst) begin
      model_cnt = 0;
      e.wrap    = 1'b0;
    end else begin
      raw       = model_cnt + (dir ? 1 : -1);
      e.wrap    = (raw < 0) || (raw >= MOD);
      model_cnt = (raw + MOD) % MOD;
    end
    e.cnt    = model_cnt;
    e.at_max = (model_cnt == MOD - 1);
    e.at_min = (model_cnt == 0);
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    bit bad;
    bad = 1'b0;
    vectors++;
    if (int'(cnt) != e.cnt) begin
      $display("[TB] FAIL cnt: got %0d expected %0d at %0t", cnt, e.cnt, $time);
      bad = 1'b1;
    end
    if (at_max !== e.at_max) begin
      $display("[TB] FAIL at_max: got %b expected %b (cnt=%0d) at %0t", at_max, e.at_max, e.cnt, $time);
      bad = 1'b1;
    end
    if (at_min !== e.at_min) begin
      $display("[TB] FAIL at_min: got %b expected %b (cnt=%0d) at %0t", at_min, e.at_min, e.cnt, $time);
      bad = 1'b1;
    end
    if (wrap !== e.wrap) begin
      $display("[TB] FAIL wrap: got %b expected %b (cnt=%0d) at %0t", wrap, e.wrap, e.cnt, $time);
      bad = 1'b1;
    end
    if (bad) miscompares++;
  endtask

  // Monitor: outputs are valid once per rising edge; compare just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int budget;
    vectors     = 0;
    miscompares = 0;
    model_cnt   = 0;
    sys_rst     = 1'b1;
    up          = 1'b1;

    // Reset hold, then up count 1..10, then down to 4.
    repeat (2) applyStimulus(1'b1, 1'b1);
    repeat (10) applyStimulus(1'b0, 1'b1);
    repeat (6) applyStimulus(1'b0, 1'b0);

    // Full up lap through the wrap.
    applyStimulus(1'b1, 1'b1);
    repeat (17) applyStimulus(1'b0, 1'b1);

    // Down wrap straight out of reset.
    applyStimulus(1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0);

    // Reset mid-count at 7.
    applyStimulus(1'b1, 1'b1);
    repeat (7) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b1);

    // Random direction with occasional reset.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)));
    end

    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(posedge sys_clk);
      #2;
      budget++;
    end
    if (sb.size() > 0) begin
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
      miscompares++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
